// File: rtl/seg_shift_tx.sv
// seg_shift_tx: serializer for the 7-segment display shift chain.
// A rising edge on start captures pdata. The block then clears the display
// chain, shifts every bit out on s_clk/sout and latches the frame. en stays
// high after the first completed frame.
// All pad-facing outputs come straight from flops, so the pads see no glitches.

module seg_shift_tx #(
    parameter int DATA_BITS = 64,
    parameter int CNT_BITS  = 6,
    parameter bit DIR       = 1'b0,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] pdata,
    output logic                 busy,
    output logic                 done,
    output logic                 s_clk,
    output logic                 s_clrn,
    output logic                 sout,
    output logic                 en
);

    // The phase counter needs at least one bit, even when CLK_DIV is 1.
    localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0]     PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [CNT_BITS-1:0] BIT_LAST = CNT_BITS'(DATA_BITS - 1);
    localparam logic [PH_W-1:0]     PH_ZERO  = {PH_W{1'b0}};
    localparam logic [CNT_BITS-1:0] BIT_ZERO = {CNT_BITS{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic                  half_q, half_d;      // 0: s_clk low phase, 1: high phase
    logic [CNT_BITS-1:0]   bit_q, bit_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  start_q;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic s_clk_q, s_clk_d;
    logic s_clrn_q, s_clrn_d;
    logic sout_q, sout_d;
    logic en_q, en_d;

    // Bit presented on sout: the end of the shift register that leaves first.
    function automatic logic head_bit(input logic [DATA_BITS-1:0] v);
        if (DIR) begin
            head_bit = v[0];
        end else begin
            head_bit = v[DATA_BITS-1];
        end
    endfunction

    // Advance the shift register by one bit toward the outgoing end.
    function automatic logic [DATA_BITS-1:0] shift_once(input logic [DATA_BITS-1:0] v);
        if (DIR) begin
            shift_once = {1'b0, v[DATA_BITS-1:1]};
        end else begin
            shift_once = {v[DATA_BITS-2:0], 1'b0};
        end
    endfunction

    // Next-state logic: frame sequencing, phase/bit counters and data capture.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        half_d  = half_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !start_q) begin
                    state_d = ST_CLEAR;
                    ph_d    = PH_ZERO;
                    half_d  = 1'b0;
                    bit_d   = BIT_ZERO;
                    shreg_d = pdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (ph_q == PH_LAST) begin
                    state_d = ST_SHIFT;
                    ph_d    = PH_ZERO;
                    half_d  = 1'b0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_SHIFT: begin
                if (ph_q == PH_LAST) begin
                    ph_d = PH_ZERO;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        // High phase finished: the display has sampled this bit.
                        half_d  = 1'b0;
                        shreg_d = shift_once(shreg_q);
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_LATCH;
                            bit_d   = BIT_ZERO;
                        end else begin
                            bit_d = bit_q + CNT_BITS'(1);
                        end
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_LATCH: begin
                if (ph_q == PH_LAST) begin
                    state_d = ST_IDLE;
                    ph_d    = PH_ZERO;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ph_d    = PH_ZERO;
                half_d  = 1'b0;
                bit_d   = BIT_ZERO;
            end
        endcase
    end

    // Pad values decoded from the next state so they are registered without delay.
    always_comb begin
        busy_d   = (state_d != ST_IDLE);
        s_clrn_d = (state_d != ST_CLEAR);
        done_d   = (state_d == ST_LATCH) && (ph_d == PH_LAST);
        en_d     = en_q | (state_d == ST_LATCH);
        if (state_d == ST_SHIFT) begin
            s_clk_d = half_d;
            sout_d  = head_bit(shreg_d);
        end else begin
            s_clk_d = 1'b0;
            sout_d  = 1'b0;
        end
    end

    // State, counters, data and output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ph_q     <= PH_ZERO;
            half_q   <= 1'b0;
            bit_q    <= BIT_ZERO;
            shreg_q  <= {DATA_BITS{1'b0}};
            start_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            s_clk_q  <= 1'b0;
            s_clrn_q <= 1'b1;
            sout_q   <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            start_q  <= start;
            busy_q   <= busy_d;
            done_q   <= done_d;
            s_clk_q  <= s_clk_d;
            s_clrn_q <= s_clrn_d;
            sout_q   <= sout_d;
            en_q     <= en_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign s_clk  = s_clk_q;
    assign s_clrn = s_clrn_q;
    assign sout   = sout_q;
    assign en     = en_q;

endmodule

// File: tb/tb_seg_shift_tx.sv
// Directed bench for seg_shift_tx.
// Instance 0 uses DIR=0 with CLK_DIV=2, instance 1 uses DIR=1 with CLK_DIV=2,
// and instance 2 uses DIR=0 with CLK_DIV=1.

module tb_seg_shift_tx;

    logic        clk;
    logic        rst;
    logic [2:0]  start_r;
    logic [63:0] pdata;
    logic [2:0]  busy_w, done_w, s_clk_w, s_clrn_w, sout_w, en_w;

    int checks_n;
    int errors_n;

    // per-run observations
    logic [63:0] word_r;
    int rises_r, done_cnt_r, done_first_r, done_last_r, busy_cnt_r, busy_low_r;
    int clr_cnt_r, clr_first_r, clr_last_r, en_first_r;
    logic first_bit_r, last_bit_r;

    seg_shift_tx #(.DATA_BITS(64), .CNT_BITS(6), .DIR(1'b0), .CLK_DIV(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .pdata(pdata),
        .busy(busy_w[0]), .done(done_w[0]), .s_clk(s_clk_w[0]),
        .s_clrn(s_clrn_w[0]), .sout(sout_w[0]), .en(en_w[0]));

    seg_shift_tx #(.DATA_BITS(64), .CNT_BITS(6), .DIR(1'b1), .CLK_DIV(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .pdata(pdata),
        .busy(busy_w[1]), .done(done_w[1]), .s_clk(s_clk_w[1]),
        .s_clrn(s_clrn_w[1]), .sout(sout_w[1]), .en(en_w[1]));

    seg_shift_tx #(.DATA_BITS(64), .CNT_BITS(6), .DIR(1'b0), .CLK_DIV(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_r[2]), .pdata(pdata),
        .busy(busy_w[2]), .done(done_w[2]), .s_clk(s_clk_w[2]),
        .s_clrn(s_clrn_w[2]), .sout(sout_w[2]), .en(en_w[2]));

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge; after it, outputs show the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one frame on instance idx for ncyc cycles after trigger cycle T.
    // mode 0: plain, 1: disturb start/pdata, 2: reset at T+100, 3: re-trigger at T+131.
    task automatic run_frame(input int idx, input logic [63:0] data, input int ncyc, input int mode);
        logic prev;
        logic b;
        start_r[idx] = 1'b0;
        tick();
        pdata        = data;
        start_r[idx] = 1'b1;               // cycle T
        word_r = 64'd0; rises_r = 0; done_cnt_r = 0; done_first_r = 0; done_last_r = 0;
        busy_cnt_r = 0; busy_low_r = 0; clr_cnt_r = 0; clr_first_r = 0; clr_last_r = 0;
        en_first_r = 0; first_bit_r = 1'b0; last_bit_r = 1'b0;
        prev = s_clk_w[idx];
        for (int k = 1; k <= ncyc; k++) begin
            tick();                        // now in cycle T+k
            if (busy_w[idx]) busy_cnt_r++;
            else if (busy_low_r == 0) busy_low_r = k;
            if (!s_clrn_w[idx]) begin
                clr_cnt_r++;
                if (clr_first_r == 0) clr_first_r = k;
                clr_last_r = k;
            end
            if (done_w[idx]) begin
                done_cnt_r++;
                if (done_first_r == 0) done_first_r = k;
                done_last_r = k;
            end
            if (en_w[idx] && en_first_r == 0) en_first_r = k;
            if (s_clk_w[idx] && !prev) begin
                b = sout_w[idx];
                rises_r++;
                if (rises_r == 1) first_bit_r = b;
                last_bit_r = b;
                if (idx == 1) word_r = {b, word_r[63:1]};
                else          word_r = {word_r[62:0], b};
            end
            prev = s_clk_w[idx];
            if (mode == 1) begin
                if (k == 10) pdata = 64'hFFFF_FFFF_FFFF_FFFF;
                if (k >= 20 && k <= 25) start_r[idx] = ~start_r[idx];
            end
            if (mode == 2) begin
                if (k == 100) rst = 1'b1;
                if (k == 101) begin
                    check_val("rst_busy",  {63'd0, busy_w[idx]},  64'd0);
                    check_val("rst_sclk",  {63'd0, s_clk_w[idx]}, 64'd0);
                    check_val("rst_en",    {63'd0, en_w[idx]},    64'd0);
                    check_val("rst_clrn",  {63'd0, s_clrn_w[idx]}, 64'd1);
                    rst = 1'b0;
                end
            end
            if (mode == 3) begin
                if (k == 130) start_r[idx] = 1'b0;
                if (k == 131) start_r[idx] = 1'b1;
            end
        end
    endtask

    initial begin
        int act;
        checks_n = 0;
        errors_n = 0;
        rst      = 1'b1;
        start_r  = 3'b111;
        pdata    = 64'd0;

        // Scenario 1: reset with start held high, then no spontaneous frame.
        repeat (3) tick();
        rst = 1'b0;
        check_val("s1_busy", {61'd0, busy_w},   64'd0);
        check_val("s1_done", {61'd0, done_w},   64'd0);
        check_val("s1_sclk", {61'd0, s_clk_w},  64'd0);
        check_val("s1_clrn", {61'd0, s_clrn_w}, 64'd7);
        check_val("s1_sout", {61'd0, sout_w},   64'd0);
        check_val("s1_en",   {61'd0, en_w},     64'd0);
        act = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy_w != 3'd0 || s_clrn_w != 3'b111 || done_w != 3'd0) act++;
        end
        check_val("s1_noframe", 64'(act), 64'd0);

        // Scenario 2: DIR=0, MSB first, full timing.
        run_frame(0, 64'h0123_4567_89AB_CDEF, 262, 0);
        check_val("s2_word",     word_r,             64'h0123_4567_89AB_CDEF);
        check_val("s2_rises",    64'(rises_r),       64'd64);
        check_val("s2_clr_cnt",  64'(clr_cnt_r),     64'd2);
        check_val("s2_clr_first",64'(clr_first_r),   64'd1);
        check_val("s2_done_cnt", 64'(done_cnt_r),    64'd1);
        check_val("s2_done_at",  64'(done_first_r),  64'd260);
        check_val("s2_busy_cnt", 64'(busy_cnt_r),    64'd260);
        check_val("s2_idle_at",  64'(busy_low_r),    64'd261);
        check_val("s2_en_at",    64'(en_first_r),    64'd259);

        // Scenario 3: DIR=1, LSB first.
        run_frame(1, 64'h0123_4567_89AB_CDEF, 262, 0);
        check_val("s3_word",     word_r,             64'h0123_4567_89AB_CDEF);
        check_val("s3_first",    {63'd0, first_bit_r}, 64'd1);
        check_val("s3_last",     {63'd0, last_bit_r},  64'd0);
        check_val("s3_rises",    64'(rises_r),       64'd64);
        check_val("s3_done_at",  64'(done_first_r),  64'd260);
        check_val("s3_idle_at",  64'(busy_low_r),    64'd261);
        check_val("s3_en_at",    64'(en_first_r),    64'd259);

        // Scenario 4: start toggles and pdata change during the frame are ignored.
        run_frame(0, 64'hA5C3_0F96_1E2D_3C4B, 262, 1);
        check_val("s4_word",     word_r,             64'hA5C3_0F96_1E2D_3C4B);
        check_val("s4_done_cnt", 64'(done_cnt_r),    64'd1);
        check_val("s4_done_at",  64'(done_first_r),  64'd260);
        check_val("s4_busy_cnt", 64'(busy_cnt_r),    64'd260);

        // Scenario 5: reset mid-frame, then a clean full frame.
        run_frame(0, 64'h0123_4567_89AB_CDEF, 262, 2);
        check_val("s5_done_cnt", 64'(done_cnt_r),    64'd0);
        check_val("s5_idle_at",  64'(busy_low_r),    64'd101);
        run_frame(0, 64'hDEAD_BEEF_0BAD_F00D, 262, 0);
        check_val("s5b_word",    word_r,             64'hDEAD_BEEF_0BAD_F00D);
        check_val("s5b_done_at", 64'(done_first_r),  64'd260);
        check_val("s5b_done_cnt",64'(done_cnt_r),    64'd1);
        check_val("s5b_en_at",   64'(en_first_r),    64'd259);

        // Scenario 6: CLK_DIV=1, back-to-back frames at earliest re-trigger.
        run_frame(2, 64'h0123_4567_89AB_CDEF, 262, 3);
        check_val("s6_done_cnt", 64'(done_cnt_r),    64'd2);
        check_val("s6_done1_at", 64'(done_first_r),  64'd130);
        check_val("s6_done2_at", 64'(done_last_r),   64'd261);
        check_val("s6_clr_cnt",  64'(clr_cnt_r),     64'd2);
        check_val("s6_clr2_at",  64'(clr_last_r),    64'd132);
        check_val("s6_busy_cnt", 64'(busy_cnt_r),    64'd260);
        check_val("s6_rises",    64'(rises_r),       64'd128);
        check_val("s6_word",     word_r,             64'h0123_4567_89AB_CDEF);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule
